// File: rtl/scc_pkg.sv
// -----------------------------------------------------------------------------
// scc_pkg
// Shared constants and types for the SCC/SCC-I sound register controller.
//   - Channel indices CH_A..CH_E and the mixer slot that commits the registers.
//   - Register-window offsets for the volume bank and the channel enable mask.
//   - Bit position of the wave-reset / SCC-I mode flag in the mode registers.
//   - chan_regs_t: one channel's frequency/volume pair.
// -----------------------------------------------------------------------------
package scc_pkg;

    localparam logic [2:0] CH_A        = 3'd0;
    localparam logic [2:0] CH_B        = 3'd1;
    localparam logic [2:0] CH_C        = 3'd2;
    localparam logic [2:0] CH_D        = 3'd3;
    localparam logic [2:0] CH_E        = 3'd4;
    localparam logic [2:0] SLOT_COMMIT = 3'd5;

    localparam logic [3:0] OFS_VOL_BASE = 4'hA;
    localparam logic [3:0] OFS_ENABLE   = 4'hF;

    localparam int MODE_BIT = 5;

    typedef struct packed {
        logic [11:0] freq;
        logic [3:0]  vol;
    } chan_regs_t;

endpackage

// File: rtl/scc_register_controller_if.sv
// -----------------------------------------------------------------------------
// scc_register_controller_if
// CPU-side write bus of the SCC register controller.
//   reg_a        register offset inside the sound-register window
//   reg_d        write data (shared by all three strobes)
//   reg_wr       sound-register write strobe
//   deform_wr    deformation register write strobe
//   scci_mode_wr SCC-I mode register write strobe
// master drives the bus (CPU decode), slave receives it (controller).
// -----------------------------------------------------------------------------
interface scc_register_controller_if;

    logic [3:0] reg_a;
    logic [7:0] reg_d;
    logic       reg_wr;
    logic       deform_wr;
    logic       scci_mode_wr;

    modport master (
        output reg_a,
        output reg_d,
        output reg_wr,
        output deform_wr,
        output scci_mode_wr
    );

    modport slave (
        input reg_a,
        input reg_d,
        input reg_wr,
        input deform_wr,
        input scci_mode_wr
    );

endinterface

// File: rtl/scc_reg_channel_bank.sv
// -----------------------------------------------------------------------------
// scc_reg_channel_bank
// Double-buffered frequency/volume registers of a single wave channel.
//   clk, reset   clock, asynchronous active-high reset
//   enable       clock enable; nothing changes while low
//   wr_freq_lo   write frequency[7:0]  from wr_data
//   wr_freq_hi   write frequency[11:8] from wr_data[3:0]
//   wr_vol       write volume          from wr_data[3:0]
//   wr_data      CPU write data
//   commit       copy shadow to committed (frame boundary)
//   committed    committed frequency/volume seen by the slot mux
// A write in the commit cycle lands in the shadow only; the committed copy
// takes the shadow value from before that write.
// -----------------------------------------------------------------------------
module scc_reg_channel_bank
    import scc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_freq_lo,
    input  logic       wr_freq_hi,
    input  logic       wr_vol,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output chan_regs_t committed
);

    chan_regs_t shadow_q;
    chan_regs_t shadow_d;
    chan_regs_t committed_q;
    chan_regs_t committed_d;

    always_comb begin
        shadow_d    = shadow_q;
        committed_d = committed_q;
        if (enable) begin
            if (commit) begin
                committed_d = shadow_q;
            end
            if (wr_freq_lo) begin
                shadow_d.freq[7:0] = wr_data;
            end
            if (wr_freq_hi) begin
                shadow_d.freq[11:8] = wr_data[3:0];
            end
            if (wr_vol) begin
                shadow_d.vol = wr_data[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            committed_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            committed_q <= committed_d;
        end
    end

    assign committed = committed_q;

endmodule

// File: rtl/scc_register_controller.sv
// -----------------------------------------------------------------------------
// scc_register_controller
// SCC/SCC-I sound register file: decodes CPU writes into shadow registers,
// commits them at the slot-frame boundary and multiplexes the committed
// values onto the mixer's single-channel register ports.
//   clk, reset           clock, asynchronous active-high reset
//   enable               clock enable; all state holds while low
//   bus                  CPU write bus (reg_a/reg_d/reg_wr/deform_wr/scci_mode_wr)
//   active               mixer slot counter (0..4 = channel A..E, 5 = commit)
//   reg_frequency_count  committed frequency of the active channel (combinational)
//   reg_volume           committed volume of the active channel, VOL_DELAY late
//   reg_enable           committed enable bit of the active channel, VOL_DELAY late
//   reg_wave_reset       deformation register bit 5
//   reg_scci_enable      SCC-I mode register bit 5
//   clear_counter        one-cycle counter-clear pulses at commit, bit0 = A
// -----------------------------------------------------------------------------
module scc_register_controller
    import scc_pkg::*;
#(
    parameter int NUM_CH    = 5,
    parameter int VOL_DELAY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    scc_register_controller_if.slave   bus,
    input  logic [2:0]                 active,
    output logic [11:0]                reg_frequency_count,
    output logic [3:0]                 reg_volume,
    output logic                       reg_enable,
    output logic                       reg_wave_reset,
    output logic                       reg_scci_enable,
    output logic [NUM_CH-1:0]          clear_counter
);

    logic              wr_en;
    logic              commit;
    logic [NUM_CH-1:0] wr_lo;
    logic [NUM_CH-1:0] wr_hi;
    logic [NUM_CH-1:0] wr_vol;
    chan_regs_t        chan [NUM_CH];

    logic [NUM_CH-1:0] mask_shadow_q, mask_shadow_d;
    logic [NUM_CH-1:0] mask_commit_q, mask_commit_d;
    logic [NUM_CH-1:0] pending_clear_q, pending_clear_d;
    logic [NUM_CH-1:0] clear_counter_q, clear_counter_d;
    logic              wave_reset_q, wave_reset_d;
    logic              scci_enable_q, scci_enable_d;

    assign wr_en  = bus.reg_wr & enable;
    assign commit = enable & (active == SLOT_COMMIT);

    // Per-channel write decode and register bank.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign wr_lo[gi]  = wr_en & (bus.reg_a == 4'(2 * gi));
        assign wr_hi[gi]  = wr_en & (bus.reg_a == 4'(2 * gi + 1));
        assign wr_vol[gi] = wr_en & (bus.reg_a == (OFS_VOL_BASE + 4'(gi)));

        scc_reg_channel_bank u_bank (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .wr_freq_lo (wr_lo[gi]),
            .wr_freq_hi (wr_hi[gi]),
            .wr_vol     (wr_vol[gi]),
            .wr_data    (bus.reg_d),
            .commit     (commit),
            .committed  (chan[gi])
        );
    end

    // Mask, pending clears, clear pulse and mode bits.
    always_comb begin
        mask_shadow_d   = mask_shadow_q;
        mask_commit_d   = mask_commit_q;
        pending_clear_d = pending_clear_q;
        clear_counter_d = clear_counter_q;
        wave_reset_d    = wave_reset_q;
        scci_enable_d   = scci_enable_q;
        if (enable) begin
            clear_counter_d = '0;
            if (commit) begin
                mask_commit_d   = mask_shadow_q;
                // The pulse is gated by the live wave-reset level at commit,
                // so a per-write wave history would add nothing observable.
                clear_counter_d = pending_clear_q & {NUM_CH{wave_reset_q}};
                pending_clear_d = '0;
            end
            // Set after the commit clear: a write in the commit cycle keeps
            // its pending bit for the next frame.
            pending_clear_d = pending_clear_d | wr_lo | wr_hi;
            if (wr_en && (bus.reg_a == OFS_ENABLE)) begin
                mask_shadow_d = bus.reg_d[NUM_CH-1:0];
            end
            if (bus.deform_wr) begin
                wave_reset_d = bus.reg_d[MODE_BIT];
            end
            if (bus.scci_mode_wr) begin
                scci_enable_d = bus.reg_d[MODE_BIT];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_shadow_q   <= '0;
            mask_commit_q   <= '0;
            pending_clear_q <= '0;
            clear_counter_q <= '0;
            wave_reset_q    <= 1'b0;
            scci_enable_q   <= 1'b0;
        end else begin
            mask_shadow_q   <= mask_shadow_d;
            mask_commit_q   <= mask_commit_d;
            pending_clear_q <= pending_clear_d;
            clear_counter_q <= clear_counter_d;
            wave_reset_q    <= wave_reset_d;
            scci_enable_q   <= scci_enable_d;
        end
    end

    // Slot mux: slots beyond the last channel select nothing and read as 0.
    logic [11:0] freq_sel;
    logic [3:0]  vol_sel;
    logic        en_sel;

    always_comb begin
        freq_sel = '0;
        vol_sel  = '0;
        en_sel   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (active == 3'(k)) begin
                freq_sel = chan[k].freq;
                vol_sel  = chan[k].vol;
                en_sel   = mask_commit_q[k];
            end
        end
    end

    assign reg_frequency_count = freq_sel;

    // Volume/enable pipeline, {enable, volume} per stage, aligned to the
    // mixer's volume stage.
    logic [VOL_DELAY:0][4:0] vol_pipe;
    assign vol_pipe[0] = {en_sel, vol_sel};

    for (genvar gi = 1; gi <= VOL_DELAY; gi++) begin : g_vol_pipe
        logic [4:0] stage_q;
        logic [4:0] stage_d;

        always_comb begin
            stage_d = stage_q;
            if (enable) begin
                stage_d = vol_pipe[gi-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign vol_pipe[gi] = stage_q;
    end

    assign reg_volume      = vol_pipe[VOL_DELAY][3:0];
    assign reg_enable      = vol_pipe[VOL_DELAY][4];
    assign reg_wave_reset  = wave_reset_q;
    assign reg_scci_enable = scci_enable_q;
    assign clear_counter   = clear_counter_q;

endmodule
